// File: rtl/instr_register_alu_pipe.sv
// Pipelined instruction register: capture {opcode, a, b}, compute a 2*OPW signed
// result in stage 1, commit to a DEPTH-entry register file in stage 2, registered read.
module instr_register_alu_pipe #(
  parameter  int OPW   = 32,
  parameter  int DEPTH = 32,
  localparam int PTRW  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load_en,
  input  logic [2:0]          opcode,
  input  logic [OPW-1:0]      operand_a,
  input  logic [OPW-1:0]      operand_b,
  input  logic [PTRW-1:0]     write_pointer,
  input  logic                clr,
  input  logic                rd_en,
  input  logic [PTRW-1:0]     read_pointer,
  output logic                rd_valid,
  output logic [2:0]          rd_opcode,
  output logic [OPW-1:0]      rd_operand_a,
  output logic [OPW-1:0]      rd_operand_b,
  output logic [2*OPW-1:0]    rd_res,
  output logic                rd_err,
  output logic                rd_entry_valid,
  output logic [15:0]         load_count
);

  // Handshake: load_en and rd_en are valid-only strobes with no ready; a load is
  // accepted at every edge where load_en=1, and rd_valid pulses one cycle per rd_en.

  localparam logic [2:0] OP_ZERO  = 3'd0;
  localparam logic [2:0] OP_PASSA = 3'd1;
  localparam logic [2:0] OP_PASSB = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_MULT  = 3'd5;
  localparam logic [2:0] OP_DIV   = 3'd6;
  localparam logic [2:0] OP_MOD   = 3'd7;

  logic                s0_valid_q;
  logic [2:0]          s0_op_q;
  logic [OPW-1:0]      s0_a_q, s0_b_q;
  logic [PTRW-1:0]     s0_ptr_q;

  logic                s1_valid_q;
  logic [2:0]          s1_op_q;
  logic [OPW-1:0]      s1_a_q, s1_b_q;
  logic [PTRW-1:0]     s1_ptr_q;
  logic [2*OPW-1:0]    s1_res_q;
  logic                s1_err_q;

  logic [2:0]          mem_op_q  [DEPTH];
  logic [OPW-1:0]      mem_a_q   [DEPTH];
  logic [OPW-1:0]      mem_b_q   [DEPTH];
  logic [2*OPW-1:0]    mem_res_q [DEPTH];
  logic [DEPTH-1:0]    mem_err_q;
  logic [DEPTH-1:0]    mem_vld_q;

  logic                rd_valid_q;
  logic [2:0]          rd_op_q;
  logic [OPW-1:0]      rd_a_q, rd_b_q;
  logic [2*OPW-1:0]    rd_res_q;
  logic                rd_err_q;
  logic                rd_vld_q;
  logic [15:0]         load_count_q;

  // Operands widened first so DIV of the most negative value by -1 cannot overflow.
  logic signed [2*OPW-1:0] a_ext, b_ext, res_d;
  logic                    err_d;
  logic                    b_zero;

  assign a_ext  = {{OPW{s0_a_q[OPW-1]}}, s0_a_q};
  assign b_ext  = {{OPW{s0_b_q[OPW-1]}}, s0_b_q};
  assign b_zero = (s0_b_q == '0);

  always_comb begin
    res_d = '0;
    err_d = 1'b0;
    case (s0_op_q)
      OP_ZERO:  res_d = '0;
      OP_PASSA: res_d = a_ext;
      OP_PASSB: res_d = b_ext;
      OP_ADD:   res_d = a_ext + b_ext;
      OP_SUB:   res_d = a_ext - b_ext;
      OP_MULT:  res_d = a_ext * b_ext;
      OP_DIV:   if (b_zero) err_d = 1'b1; else res_d = a_ext / b_ext;
      OP_MOD:   if (b_zero) err_d = 1'b1; else res_d = a_ext % b_ext;
      default:  res_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_valid_q   <= 1'b0;
      s0_op_q      <= '0;
      s0_a_q       <= '0;
      s0_b_q       <= '0;
      s0_ptr_q     <= '0;
      s1_valid_q   <= 1'b0;
      s1_op_q      <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_ptr_q     <= '0;
      s1_res_q     <= '0;
      s1_err_q     <= 1'b0;
      load_count_q <= '0;
    end else begin
      s0_valid_q <= load_en;
      if (load_en) begin
        s0_op_q  <= opcode;
        s0_a_q   <= operand_a;
        s0_b_q   <= operand_b;
        s0_ptr_q <= write_pointer;
        if (load_count_q != 16'hFFFF) load_count_q <= load_count_q + 16'd1;
      end
      s1_valid_q <= s0_valid_q;
      if (s0_valid_q) begin
        s1_op_q  <= s0_op_q;
        s1_a_q   <= s0_a_q;
        s1_b_q   <= s0_b_q;
        s1_ptr_q <= s0_ptr_q;
        s1_res_q <= res_d;
        s1_err_q <= err_d;
      end
    end
  end

  // The stage-2 write is ordered after clr so a coincident write leaves its valid bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_op_q[i]  <= '0;
        mem_a_q[i]   <= '0;
        mem_b_q[i]   <= '0;
        mem_res_q[i] <= '0;
      end
      mem_err_q <= '0;
      mem_vld_q <= '0;
    end else begin
      if (clr) mem_vld_q <= '0;
      if (s1_valid_q) begin
        mem_op_q[s1_ptr_q]  <= s1_op_q;
        mem_a_q[s1_ptr_q]   <= s1_a_q;
        mem_b_q[s1_ptr_q]   <= s1_b_q;
        mem_res_q[s1_ptr_q] <= s1_res_q;
        mem_err_q[s1_ptr_q] <= s1_err_q;
        mem_vld_q[s1_ptr_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_op_q    <= '0;
      rd_a_q     <= '0;
      rd_b_q     <= '0;
      rd_res_q   <= '0;
      rd_err_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_op_q  <= mem_op_q[read_pointer];
        rd_a_q   <= mem_a_q[read_pointer];
        rd_b_q   <= mem_b_q[read_pointer];
        rd_res_q <= mem_res_q[read_pointer];
        rd_err_q <= mem_err_q[read_pointer];
        rd_vld_q <= mem_vld_q[read_pointer];
      end
    end
  end

  assign rd_valid       = rd_valid_q;
  assign rd_opcode      = rd_op_q;
  assign rd_operand_a   = rd_a_q;
  assign rd_operand_b   = rd_b_q;
  assign rd_res         = rd_res_q;
  assign rd_err         = rd_err_q;
  assign rd_entry_valid = rd_vld_q;
  assign load_count     = load_count_q;

endmodule

// File: doc/instr_register_alu_pipe.md
# instr_register_alu_pipe

Parametrised, pipelined successor to the instruction register. It captures `{opcode, operand_a, operand_b}` on load and computes a full-width signed result in a dedicated pipeline stage. It then writes the instruction plus result, error and valid flags into a DEPTH-entry register file, and returns whole entries through a registered read port. It sits between the stimulus/test driver and any result checker, on a single clock domain.

## Interface
- `OPW`, 32, operand width in bits (signed), ≥ 2
- `DEPTH`, 32, register-file entries, power of two, ≥ 2
- `PTRW`, `$clog2(DEPTH)`, pointer width (derived, not overridden)
- `clk` input 1: single clock, all state on rising edge
- `reset_n` input 1: asynchronous, active-low reset
- `load_en` input 1: accept one instruction this edge
- `opcode` input 3: 0 ZERO, 1 PASSA, 2 PASSB, 3 ADD, 4 SUB, 5 MULT, 6 DIV, 7 MOD
- `operand_a` input OPW: signed operand A
- `operand_b` input OPW: signed operand B
- `write_pointer` input PTRW: destination entry for the load
- `clr` input 1: synchronous clear of all entry valid bits
- `rd_en` input 1: issue a read this edge
- `read_pointer` input PTRW: entry to read
- `rd_valid` output 1: read data valid (one-cycle pulse per `rd_en`)
- `rd_opcode` output 3: stored opcode
- `rd_operand_a` output OPW: stored operand A
- `rd_operand_b` output OPW: stored operand B
- `rd_res` output 2*OPW: stored signed result
- `rd_err` output 1: stored error flag (divide/modulo by zero)
- `rd_entry_valid` output 1: entry written since last reset/clr
- `load_count` output 16: number of accepted loads, saturates at 16'hFFFF

## Operation
- Stage 0 (edge E): when `load_en`=1, register `{opcode, a, b, write_pointer}` and set s0_valid. Loads are accepted every cycle; there is no backpressure.
- Stage 1 (edge E+1): compute the result into a 2*OPW signed register and carry the error flag.
  - ZERO: res = 0.
  - PASSA / PASSB: sign-extended operand.
  - ADD / SUB: sign-extended a ± b. Overflow is impossible in 2*OPW.
  - MULT: full signed product.
  - DIV: truncate toward zero. For -2^(OPW-1) / -1 the result is +2^(OPW-1), which fits.
  - MOD: remainder takes the sign of the dividend.
  - DIV or MOD with b=0: res = 0, err = 1. In every other case err = 0.
- Stage 2 (edge E+2): write `{opcode, a, b, res, err}` to entry `write_pointer` and set its valid bit.
- Back-to-back loads to the same pointer: the later load's contents win.
- `clr`=1 clears every valid bit at that edge. Data fields are unchanged.
- If a stage-2 write coincides with `clr`, the written entry's valid bit ends at 1 (write wins).
- Loads already in the pipeline when `clr` is asserted complete normally.
- Read: `rd_en`=1 at edge R samples the entry at `read_pointer`. All `rd_*` outputs update at edge R, with `rd_valid`=1 for exactly one cycle.
  - Without `rd_en`, the `rd_*` data outputs hold their value and `rd_valid` = 0.
- `load_count` increments on every accepted load and saturates at 16'hFFFF.
- Reset (`reset_n`=0, asynchronous):
  - All entries are zeroed: opcode 0, operands 0, res 0, err 0, valid 0.
  - Pipeline valid flags clear, so in-flight loads are discarded.
  - All outputs go to 0, including `rd_valid` and `load_count`.
  - Reset asserted mid-pipeline never produces a partial write after release.

## Timing
- Load-to-file latency is 2 edges. A load at edge E is written at edge E+2.
- Read latency is 1 edge. Output data is valid from edge R until the next `rd_en` edge or reset.
- Read and write to the same entry at the same edge: the read returns the old contents. A read at E+3 or later returns the new contents.
- Throughput: one load and one read per cycle, simultaneously, with independent pointers.
- The first edge after `reset_n` deasserts may accept a load.

## Test plan
- Reset then read all entries: every `rd_*` = 0, `rd_entry_valid`=0, `rd_valid` pulses once per read, `load_count`=0.
- OPW=32, load ADD a=32'h7FFFFFFF, b=1 at ptr 3; read at E+3 → `rd_res`=64'h0000_0000_8000_0000, err=0, valid=1.
  - Also: MULT a=-3, b=7 → -21 sign-extended.
  - Also: DIV a=-7, b=2 → -3.
  - Also: MOD a=-7, b=2 → -1.
- DIV a=5, b=0 → res=0, err=1. MOD a=-2^31, b=-1 → res=0, err=0.
- Load to ptr 5 at edge E and read ptr 5 at E+2 → old contents (zeros). Read at E+3 → new entry. Two consecutive loads to ptr 5 → second wins.
- Loads on 4 consecutive edges, then assert `clr` on the edge the second is written:
  - The first entry's valid bit = 0.
  - The second, third and fourth entries' valid bits = 1.
  - `load_count`=4.
- Assert `reset_n` low one cycle after a load; release and read that pointer → `rd_entry_valid`=0 and `load_count`=0.
